// File: rtl/cpu_pkg.sv
// Shared RV32I decode constants and ALU operation encoding for cpu_core.
// Pure definitions: no latency, no flow control.
package cpu_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_MEM_B  = 3'b000;
    localparam logic [2:0] F3_MEM_H  = 3'b001;
    localparam logic [2:0] F3_MEM_W  = 3'b010;
    localparam logic [2:0] F3_MEM_BU = 3'b100;
    localparam logic [2:0] F3_MEM_HU = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_t;

    typedef enum logic [1:0] {WB_ALU, WB_LOAD, WB_LINK} wb_sel_t;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic alu_op_t alu_op_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        op = ALU_ADD;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational integer ALU; branch comparisons live in the core.
// Zero latency, no backpressure.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  alu_op_t         op_i,
    output logic [XLEN-1:0] result_o
);

    logic [4:0] shamt;
    assign shamt = b_i[4:0];

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:    result_o = a_i + b_i;
            ALU_SUB:    result_o = a_i - b_i;
            ALU_SLL:    result_o = a_i << shamt;
            ALU_SLT:    result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU:   result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
            ALU_XOR:    result_o = a_i ^ b_i;
            ALU_SRL:    result_o = a_i >> shamt;
            ALU_SRA:    result_o = $unsigned($signed(a_i) >>> shamt);
            ALU_OR:     result_o = a_i | b_i;
            ALU_AND:    result_o = a_i & b_i;
            ALU_PASS_B: result_o = b_i;
            default:    result_o = '0;
        endcase
    end

endmodule

// File: rtl/cpu_core.sv
// Single-cycle RV32I core with debug-loadable imem; one instruction retires per clock.
// No backpressure: reads are combinational, all writes land on the rising edge.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dbg_wr_en,
    input  logic [XLEN-1:0] dbg_addr,
    input  logic [XLEN-1:0] dbg_instr
);

    localparam int IA = $clog2(IMEM_DEPTH);
    localparam int DA = $clog2(DMEM_DEPTH);
    localparam logic [XLEN-1:0] PC_MASK = XLEN'(IMEM_DEPTH * 4 - 4);

    logic [XLEN-1:0] imem [0:IMEM_DEPTH-1];
    logic [XLEN-1:0] dmem [0:DMEM_DEPTH-1];
    logic [XLEN-1:0] regs [0:31];
    logic [XLEN-1:0] pc, pc_d, pc_plus4;

    logic [XLEN-1:0] instr, rs1_val, rs2_val;
    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic [XLEN-1:0] alu_a, alu_b, alu_res, wb_val, load_val;
    logic [XLEN-1:0] ld_word, st_word;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [DA-1:0]   dmem_idx;
    alu_op_t         alu_op;
    wb_sel_t         wb_sel;
    logic            reg_we, mem_we, br_taken, is_jal, is_jalr;
    logic            unused_dbg;

    assign unused_dbg = ^{dbg_addr[XLEN-1:IA+2], dbg_addr[1:0]};

    assign instr    = imem[pc[IA+1:2]];
    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign f3       = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign rs1_val  = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign pc_plus4 = pc + XLEN'(4);

    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    cpu_alu #(.XLEN(XLEN)) u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .op_i     (alu_op),
        .result_o (alu_res)
    );

    always_comb begin
        alu_a    = rs1_val;
        alu_b    = imm_i;
        alu_op   = ALU_ADD;
        wb_sel   = WB_ALU;
        reg_we   = 1'b0;
        mem_we   = 1'b0;
        br_taken = 1'b0;
        is_jal   = 1'b0;
        is_jalr  = 1'b0;
        case (opcode)
            OPC_LUI: begin
                alu_b  = imm_u;
                alu_op = ALU_PASS_B;
                reg_we = 1'b1;
            end
            OPC_AUIPC: begin
                alu_a  = pc;
                alu_b  = imm_u;
                reg_we = 1'b1;
            end
            OPC_JAL: begin
                is_jal = 1'b1;
                wb_sel = WB_LINK;
                reg_we = 1'b1;
            end
            OPC_JALR: begin
                is_jalr = 1'b1;
                wb_sel  = WB_LINK;
                reg_we  = 1'b1;
            end
            OPC_BRANCH: begin
                case (f3)
                    F3_BEQ:  br_taken = (rs1_val == rs2_val);
                    F3_BNE:  br_taken = (rs1_val != rs2_val);
                    F3_BLT:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
                    F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
                    F3_BLTU: br_taken = (rs1_val < rs2_val);
                    F3_BGEU: br_taken = (rs1_val >= rs2_val);
                    default: br_taken = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                wb_sel = WB_LOAD;
                reg_we = (f3 == F3_MEM_B) || (f3 == F3_MEM_H) || (f3 == F3_MEM_W) ||
                         (f3 == F3_MEM_BU) || (f3 == F3_MEM_HU);
            end
            OPC_STORE: begin
                alu_b  = imm_s;
                mem_we = (f3 == F3_MEM_B) || (f3 == F3_MEM_H) || (f3 == F3_MEM_W);
            end
            OPC_OP_IMM: begin
                alu_op = alu_op_from_f3(f3, (f3 == F3_SRL_SRA) && instr[30]);
                reg_we = 1'b1;
            end
            OPC_OP: begin
                alu_b  = rs2_val;
                alu_op = alu_op_from_f3(f3, instr[30]);
                reg_we = 1'b1;
            end
            default: ;
        endcase
    end

    // Byte lanes are little-endian; word accesses simply drop addr[1:0].
    assign dmem_idx = alu_res[DA+1:2];
    assign ld_word  = dmem[dmem_idx];
    assign ld_byte  = ld_word[{alu_res[1:0], 3'b000} +: 8];
    assign ld_half  = ld_word[{alu_res[1], 4'b0000} +: 16];

    always_comb begin
        load_val = ld_word;
        st_word  = rs2_val;
        case (f3)
            F3_MEM_B:  load_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            F3_MEM_H:  load_val = {{(XLEN-16){ld_half[15]}}, ld_half};
            F3_MEM_BU: load_val = {{(XLEN-8){1'b0}}, ld_byte};
            F3_MEM_HU: load_val = {{(XLEN-16){1'b0}}, ld_half};
            default:   load_val = ld_word;
        endcase
        if (f3 == F3_MEM_B) begin
            st_word = ld_word;
            st_word[{alu_res[1:0], 3'b000} +: 8] = rs2_val[7:0];
        end else if (f3 == F3_MEM_H) begin
            st_word = ld_word;
            st_word[{alu_res[1], 4'b0000} +: 16] = rs2_val[15:0];
        end
    end

    always_comb begin
        case (wb_sel)
            WB_LOAD: wb_val = load_val;
            WB_LINK: wb_val = pc_plus4;
            default: wb_val = alu_res;
        endcase
    end

    always_comb begin
        pc_d = pc_plus4;
        if (is_jalr) begin
            pc_d = alu_res & ~{{(XLEN-1){1'b0}}, 1'b1};
        end else if (is_jal) begin
            pc_d = pc + imm_j;
        end else if (br_taken) begin
            pc_d = pc + imm_b;
        end
        pc_d = pc_d & PC_MASK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            for (int j = 0; j < DMEM_DEPTH; j++) dmem[j] <= '0;
        end else begin
            pc <= pc_d;
            if (reg_we && (rd != 5'd0)) regs[rd] <= wb_val;
            if (mem_we) dmem[dmem_idx] <= st_word;
        end
    end

    // Not reset: programs are loaded through this port while the core is held in reset.
    always_ff @(posedge clk) begin
        if (dbg_wr_en) imem[dbg_addr[IA+1:2]] <= dbg_instr;
    end

endmodule

// File: tb/tb_cpu_core.sv
// Directed self-checking bench for cpu_core: programs are loaded through the
// debug port under reset, then architectural state is checked after fixed cycle counts.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbg_wr_en;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_instr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_core #(.XLEN(32), .IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .dbg_wr_en (dbg_wr_en),
        .dbg_addr  (dbg_addr),
        .dbg_instr (dbg_instr)
    );

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rd, opc};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic dbg_write(input logic [31:0] a, input logic [31:0] d);
        dbg_wr_en = 1'b1;
        dbg_addr  = a;
        dbg_instr = d;
        @(negedge clk);
        dbg_wr_en = 1'b0;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) dbg_write(32'(i * 4), 32'h0);
    endtask

    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;

    logic [31:0] sw_instr;

    initial begin
        rst       = 1'b1;
        dbg_wr_en = 1'b0;
        dbg_addr  = '0;
        dbg_instr = '0;
        step(2);
        chk("reset_pc", dut.pc, 32'h0);
        chk("reset_x5", dut.regs[5], 32'h0);
        chk("reset_dmem10", dut.dmem[10], 32'h0);

        // Debug load then execute; word 0 is zero and behaves as a NOP.
        clear_imem();
        dbg_write(32'h4, 32'hE7508113);
        dbg_write(32'h8, 32'h00202023);
        chk("imem_loaded", dut.imem[1], 32'hE7508113);
        rst = 1'b0;
        step(1);
        chk("nop_pc", dut.pc, 32'h4);
        chk("nop_x2", dut.regs[2], 32'h0);
        step(1);
        chk("addi_neg", dut.regs[2], 32'hFFFFFE75);
        step(1);
        chk("sw_dmem0", dut.dmem[0], 32'hFFFFFE75);
        chk("sw_pc", dut.pc, 32'hC);

        // x0 immutability and arithmetic edge cases.
        rst = 1'b1;
        step(1);
        clear_imem();
        dbg_write(32'd0,  enc_i(12'd5, 5'd0, 3'd0, 5'd0, OPI));
        dbg_write(32'd4,  enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd3));
        dbg_write(32'd8,  enc_u(20'h80000, 5'd4, LUI));
        dbg_write(32'd12, enc_i(12'h41F, 5'd4, 3'd5, 5'd5, OPI));
        dbg_write(32'd16, enc_i(12'd1, 5'd0, 3'd0, 5'd6, OPI));
        dbg_write(32'd20, enc_r(7'h00, 5'd5, 5'd6, 3'd3, 5'd7));
        dbg_write(32'd24, enc_r(7'h00, 5'd5, 5'd6, 3'd2, 5'd8));
        dbg_write(32'd28, enc_u(20'h80000, 5'd9, LUI));
        dbg_write(32'd32, enc_i(12'hFFF, 5'd9, 3'd0, 5'd9, OPI));
        dbg_write(32'd36, enc_r(7'h00, 5'd6, 5'd9, 3'd0, 5'd10));
        dbg_write(32'd40, enc_r(7'h20, 5'd5, 5'd6, 3'd0, 5'd11));
        dbg_write(32'd44, enc_i(12'h0F0, 5'd5, 3'd4, 5'd12, OPI));
        dbg_write(32'd48, enc_i(12'h01F, 5'd6, 3'd1, 5'd13, OPI));
        dbg_write(32'd52, enc_i(12'h01F, 5'd4, 3'd5, 5'd14, OPI));
        dbg_write(32'd56, enc_i(12'h000, 5'd5, 3'd2, 5'd15, OPI));
        rst = 1'b0;
        step(15);
        chk("x0_zero", dut.regs[0], 32'h0);
        chk("add_x0_x0", dut.regs[3], 32'h0);
        chk("lui", dut.regs[4], 32'h80000000);
        chk("srai_31", dut.regs[5], 32'hFFFFFFFF);
        chk("sltu", dut.regs[7], 32'h1);
        chk("slt", dut.regs[8], 32'h0);
        chk("addi_m1", dut.regs[9], 32'h7FFFFFFF);
        chk("add_ovf", dut.regs[10], 32'h80000000);
        chk("sub", dut.regs[11], 32'h2);
        chk("xori", dut.regs[12], 32'hFFFFFF0F);
        chk("slli_31", dut.regs[13], 32'h80000000);
        chk("srli_31", dut.regs[14], 32'h1);
        chk("slti", dut.regs[15], 32'h1);
        chk("arith_pc", dut.pc, 32'd60);

        // Sub-word stores/loads, with a reset pulse landing on the first store.
        rst = 1'b1;
        step(1);
        clear_imem();
        sw_instr = enc_s(12'h010, 5'd1, 5'd0, 3'd2);
        dbg_write(32'd0,  enc_u(20'h11223, 5'd1, LUI));
        dbg_write(32'd4,  enc_i(12'h344, 5'd1, 3'd0, 5'd1, OPI));
        dbg_write(32'd8,  sw_instr);
        dbg_write(32'd12, enc_i(12'h0AA, 5'd0, 3'd0, 5'd2, OPI));
        dbg_write(32'd16, enc_s(12'h011, 5'd2, 5'd0, 3'd0));
        dbg_write(32'd20, enc_i(12'h011, 5'd0, 3'd0, 5'd3, LD));
        dbg_write(32'd24, enc_i(12'h012, 5'd0, 3'd5, 5'd4, LD));
        dbg_write(32'd28, enc_i(12'h010, 5'd0, 3'd1, 5'd5, LD));
        dbg_write(32'd32, enc_i(12'h011, 5'd0, 3'd4, 5'd6, LD));
        dbg_write(32'd36, enc_s(12'h012, 5'd2, 5'd0, 3'd1));
        dbg_write(32'd40, enc_i(12'h013, 5'd0, 3'd2, 5'd7, LD));
        rst = 1'b0;
        step(2);
        chk("pre_store_pc", dut.pc, 32'h8);
        chk("pre_store_x1", dut.regs[1], 32'h11223344);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_store_dropped", dut.dmem[4], 32'h0);
        chk("rst_pc", dut.pc, 32'h0);
        chk("rst_x1", dut.regs[1], 32'h0);
        chk("rst_imem_kept", dut.imem[2], sw_instr);
        step(3);
        chk("sw_word", dut.dmem[4], 32'h11223344);
        step(2);
        chk("sb_lane1", dut.dmem[4], 32'h1122AA44);
        step(6);
        chk("lb_sext", dut.regs[3], 32'hFFFFFFAA);
        chk("lhu_hi", dut.regs[4], 32'h00001122);
        chk("lh_sext", dut.regs[5], 32'hFFFFAA44);
        chk("lbu", dut.regs[6], 32'h000000AA);
        chk("sh_hi", dut.dmem[4], 32'h00AAAA44);
        chk("lw_misaligned", dut.regs[7], 32'h00AAAA44);

        // Control flow; the JALR word goes through a wrapped, unaligned debug address.
        rst = 1'b1;
        step(1);
        clear_imem();
        dbg_write(32'd0,  enc_b(13'd8, 5'd0, 5'd0, 3'd0));
        dbg_write(32'd4,  enc_i(12'd1, 5'd0, 3'd0, 5'd5, OPI));
        dbg_write(32'd8,  enc_j(21'd12, 5'd1));
        dbg_write(32'd12, enc_i(12'd2, 5'd0, 3'd0, 5'd6, OPI));
        dbg_write(32'd16, enc_i(12'd3, 5'd0, 3'd0, 5'd7, OPI));
        dbg_write(32'd20, enc_i(12'd4, 5'd0, 3'd0, 5'd8, OPI));
        dbg_write(32'h41B, enc_i(12'd1, 5'd1, 3'd0, 5'd0, 7'b1100111));
        rst = 1'b0;
        step(1);
        chk("beq_taken_pc", dut.pc, 32'd8);
        step(1);
        chk("jal_pc", dut.pc, 32'd20);
        chk("jal_link", dut.regs[1], 32'd12);
        step(2);
        chk("jalr_pc", dut.pc, 32'd12);
        chk("beq_skipped", dut.regs[5], 32'h0);
        chk("jal_skipped", dut.regs[7], 32'h0);
        step(1);
        chk("after_return", dut.regs[6], 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
